// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and a
// small helper for the counter width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; never below one bit so tiny widths still elaborate.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, purely combinational; shared by the serial
// datapath one bit per clock.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder controller: feeds one fulladder LSB-first over WIDTH clocks
// with a registered carry, then presents sum/cout/ovf with a one-cycle done.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("serial_adder: WIDTH must be at least 2");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  // Partial sum keeps only WIDTH-1 bits: the final bit comes straight from
  // the adder on the completing edge.
  logic [WIDTH-2:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] rs_shift;

  fulladder u_fa (
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign rs_shift = {fa_s, rs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            cnt   <= '0;
            rs    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          rs  <= rs_shift[WIDTH-1:1];
          c   <= fa_cout;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= rs_shift;
            cout  <= fa_cout;
            // c still holds the carry into the MSB on this edge.
            ovf   <= c ^ fa_cout;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
